// File: rtl/jt5205_feed.sv
// jt5205_feed: ADPCM nibble sequencer feeding an MSM5205-compatible decoder.
// Streams an inclusive byte range from sample ROM, splits each byte into two
// 4-bit codes and keeps din loaded with the code for the next decoder irq.
module jt5205_feed #(
    parameter int AW       = 16,
    parameter int HI_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          irq,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [3:0]    din,
    output logic          adpcm_rst,
    output logic          busy,
    output logic          done,
    output logic          underrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t        state_r, state_n;
    logic [AW-1:0] fa_r, fa_n;
    logic [AW-1:0] end_r, end_n;
    logic [7:0]    cur_r, cur_n;
    logic          pend_r, pend_n;     // second nibble of cur still to play
    logic [7:0]    nxt_r, nxt_n;
    logic          nxt_v_r, nxt_v_n;
    logic          last_r, last_n;     // final byte of the range already fetched
    logic          starve_r, starve_n; // din holds no valid code after an underrun
    logic          cs_r, cs_n;
    logic          first_r, first_n;   // first cycle of a new ROM request
    logic [3:0]    din_r, din_n;
    logic          arst_r, arst_n;
    logic          busy_r, busy_n;
    logic          done_r, done_n;
    logic          underrun_r, underrun_n;
    logic          accept_s;

    function automatic logic [3:0] first_nib(input logic [7:0] b);
        if (HI_FIRST != 0) first_nib = b[7:4];
        else               first_nib = b[3:0];
    endfunction

    function automatic logic [3:0] second_nib(input logic [7:0] b);
        if (HI_FIRST != 0) second_nib = b[3:0];
        else               second_nib = b[7:4];
    endfunction

    // ROM data is only trusted once the request has been stable for a cycle
    assign accept_s = cs_r & rom_ok & ~first_r;

    assign rom_addr  = fa_r;
    assign rom_cs    = cs_r;
    assign din       = din_r;
    assign adpcm_rst = arst_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign underrun  = underrun_r;

    // Next-state logic: fetch engine, nibble sequencing and host commands
    always_comb begin
        state_n    = state_r;
        fa_n       = fa_r;
        end_n      = end_r;
        cur_n      = cur_r;
        pend_n     = pend_r;
        nxt_n      = nxt_r;
        nxt_v_n    = nxt_v_r;
        last_n     = last_r;
        starve_n   = starve_r;
        din_n      = din_r;
        arst_n     = arst_r;
        busy_n     = busy_r;
        done_n     = 1'b0;
        underrun_n = underrun_r;

        if (accept_s) begin
            if (fa_r == end_r) last_n = 1'b1;
            else               fa_n   = fa_r + AW'(1);
        end else begin
            fa_n = fa_r;
        end

        case (state_r)
            IDLE: begin
                state_n = IDLE;
            end
            LOAD: begin
                if (accept_s) begin
                    cur_n    = rom_data;
                    pend_n   = 1'b1;
                    din_n    = first_nib(rom_data);
                    arst_n   = 1'b0;
                    starve_n = 1'b0;
                    state_n  = PLAY;
                end else begin
                    state_n = LOAD;
                end
            end
            PLAY: begin
                if (irq) begin
                    if (pend_r) begin
                        din_n  = second_nib(cur_r);
                        pend_n = 1'b0;
                        if (accept_s) begin
                            nxt_n   = rom_data;
                            nxt_v_n = 1'b1;
                        end else begin
                            nxt_v_n = nxt_v_r;
                        end
                    end else if (nxt_v_r) begin
                        cur_n    = nxt_r;
                        din_n    = first_nib(nxt_r);
                        pend_n   = 1'b1;
                        nxt_n    = rom_data;
                        nxt_v_n  = accept_s;
                        starve_n = 1'b0;
                    end else if (accept_s) begin
                        // byte arriving with the irq still counts as on time
                        cur_n    = rom_data;
                        din_n    = first_nib(rom_data);
                        pend_n   = 1'b1;
                        starve_n = 1'b0;
                    end else if (last_r) begin
                        state_n  = IDLE;
                        done_n   = 1'b1;
                        busy_n   = 1'b0;
                        arst_n   = 1'b1;
                        din_n    = 4'd0;
                        starve_n = 1'b0;
                    end else begin
                        underrun_n = 1'b1;
                        din_n      = 4'd0;
                        starve_n   = 1'b1;
                    end
                end else if (accept_s) begin
                    if (starve_r) begin
                        // late byte goes straight to din for the next irq
                        cur_n    = rom_data;
                        din_n    = first_nib(rom_data);
                        pend_n   = 1'b1;
                        starve_n = 1'b0;
                    end else begin
                        nxt_n   = rom_data;
                        nxt_v_n = 1'b1;
                    end
                end else begin
                    state_n = PLAY;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (stop) begin
            state_n  = IDLE;
            busy_n   = 1'b0;
            arst_n   = 1'b1;
            din_n    = 4'd0;
            pend_n   = 1'b0;
            nxt_v_n  = 1'b0;
            last_n   = 1'b0;
            starve_n = 1'b0;
            done_n   = 1'b0;
        end else if (start) begin
            state_n    = LOAD;
            fa_n       = start_addr;
            end_n      = end_addr;
            underrun_n = 1'b0;
            busy_n     = 1'b1;
            arst_n     = 1'b1;
            din_n      = 4'd0;
            pend_n     = 1'b0;
            nxt_v_n    = 1'b0;
            last_n     = 1'b0;
            starve_n   = 1'b0;
            done_n     = 1'b0;
        end else begin
            state_n = state_n;
        end

        cs_n = ((state_n == LOAD) && !last_n) ||
               ((state_n == PLAY) && !nxt_v_n && !last_n);
        // restarts and address changes begin a fresh request
        first_n = cs_n && (!cs_r || (fa_n != fa_r) || (start && !stop));
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            fa_r       <= '0;
            end_r      <= '0;
            cur_r      <= 8'd0;
            pend_r     <= 1'b0;
            nxt_r      <= 8'd0;
            nxt_v_r    <= 1'b0;
            last_r     <= 1'b0;
            starve_r   <= 1'b0;
            cs_r       <= 1'b0;
            first_r    <= 1'b0;
            din_r      <= 4'd0;
            arst_r     <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            fa_r       <= fa_n;
            end_r      <= end_n;
            cur_r      <= cur_n;
            pend_r     <= pend_n;
            nxt_r      <= nxt_n;
            nxt_v_r    <= nxt_v_n;
            last_r     <= last_n;
            starve_r   <= starve_n;
            cs_r       <= cs_n;
            first_r    <= first_n;
            din_r      <= din_n;
            arst_r     <= arst_n;
            busy_r     <= busy_n;
            done_r     <= done_n;
            underrun_r <= underrun_n;
        end
    end

endmodule

// File: tb/tb_jt5205_feed.sv
// Directed testbench for jt5205_feed: two instances (high-first and
// low-first) driven from one ROM image with hand-computed nibble sequences.
module tb_jt5205_feed;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq, start, stop;
    logic [15:0] start_addr, end_addr;
    logic [15:0] rom_addr, rom_addr_lo;
    logic        rom_cs, rom_cs_lo;
    logic [7:0]  rom_data, rom_data_lo;
    logic        rom_ok, rom_ok_lo;
    logic [3:0]  din, din_lo;
    logic        adpcm_rst, adpcm_rst_lo;
    logic        busy, busy_lo;
    logic        done, done_lo;
    logic        underrun, underrun_lo;

    logic [7:0]  rom [0:65535];
    logic        hold_en;
    logic [15:0] hold_addr;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    // ROM model: zero-wait, except one address can be held off
    assign rom_data    = rom[rom_addr];
    assign rom_ok      = rom_cs & ~(hold_en & (rom_addr == hold_addr));
    assign rom_data_lo = rom[rom_addr_lo];
    assign rom_ok_lo   = rom_cs_lo;

    // count done pulses from the high-first instance
    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    jt5205_feed #(.AW(16), .HI_FIRST(1)) dut (
        .clk(clk), .rst(rst), .irq(irq), .start(start), .stop(stop),
        .start_addr(start_addr), .end_addr(end_addr),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .din(din), .adpcm_rst(adpcm_rst), .busy(busy), .done(done), .underrun(underrun)
    );

    jt5205_feed #(.AW(16), .HI_FIRST(0)) dut_lo (
        .clk(clk), .rst(rst), .irq(irq), .start(start), .stop(stop),
        .start_addr(start_addr), .end_addr(end_addr),
        .rom_addr(rom_addr_lo), .rom_cs(rom_cs_lo), .rom_data(rom_data_lo), .rom_ok(rom_ok_lo),
        .din(din_lo), .adpcm_rst(adpcm_rst_lo), .busy(busy_lo), .done(done_lo), .underrun(underrun_lo)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_irq;
        irq = 1'b1;
        tick(1);
        irq = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] a, input logic [15:0] e);
        start_addr = a;
        end_addr   = e;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic pulse_stop;
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({rom_addr, rom_cs, din, adpcm_rst, busy, done, underrun} !== {16'h0000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got addr=%h cs=%b din=%h arst=%b busy=%b done=%b ur=%b want 0000 0 0 1 0 0 0",
                     rom_addr, rom_cs, din, adpcm_rst, busy, done, underrun);
        end
    endtask

    task automatic test_basic;
        logic [3:0] e_hi [4];
        logic [3:0] e_lo [4];
        int d0;
        e_hi = '{4'h1, 4'h2, 4'h3, 4'h4};
        e_lo = '{4'h2, 4'h1, 4'h4, 4'h3};
        d0 = done_cnt;
        pulse_start(16'h0010, 16'h0011);
        tick(30);
        checks++;
        if (busy !== 1'b1 || adpcm_rst !== 1'b0) begin
            errors++;
            $display("FAIL basic_playing: got busy=%b arst=%b want 1 0", busy, adpcm_rst);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (din !== e_hi[k]) begin
                errors++;
                $display("FAIL basic_hi_din%0d: got %h want %h", k, din, e_hi[k]);
            end
            checks++;
            if (din_lo !== e_lo[k]) begin
                errors++;
                $display("FAIL basic_lo_din%0d: got %h want %h", k, din_lo, e_lo[k]);
            end
            pulse_irq;
            if (k < 3) tick(31);
        end
        checks++;
        if ({done, busy, adpcm_rst, din, underrun, done_lo} !== {1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL basic_end: got done=%b busy=%b arst=%b din=%h ur=%b done_lo=%b want 1 0 1 0 0 1",
                     done, busy, adpcm_rst, din, underrun, done_lo);
        end
        tick(3);
        checks++;
        if (done_cnt !== d0 + 1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_once: got count=%0d done=%b want %0d 0", done_cnt - d0, done, 1);
        end
    endtask

    task automatic test_wrap;
        logic [3:0] e [4];
        e = '{4'hA, 4'hB, 4'hC, 4'hD};
        pulse_start(16'hFFFF, 16'h0000);
        checks++;
        if (rom_addr !== 16'hFFFF || rom_cs !== 1'b1) begin
            errors++;
            $display("FAIL wrap_addr0: got %h cs=%b want ffff 1", rom_addr, rom_cs);
        end
        tick(2);
        checks++;
        if (rom_addr !== 16'h0000 || din !== 4'hA) begin
            errors++;
            $display("FAIL wrap_addr1: got addr=%h din=%h want 0000 a", rom_addr, din);
        end
        tick(27);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (din !== e[k]) begin
                errors++;
                $display("FAIL wrap_din%0d: got %h want %h", k, din, e[k]);
            end
            pulse_irq;
            if (k < 3) tick(31);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: got done=%b busy=%b want 1 0", done, busy);
        end
        tick(2);
    endtask

    task automatic test_underrun;
        hold_addr = 16'h0011;
        hold_en   = 1'b1;
        pulse_start(16'h0010, 16'h0011);
        tick(7);
        checks++;
        if (din !== 4'h1) begin
            errors++;
            $display("FAIL ur_din0: got %h want 1", din);
        end
        pulse_irq;
        tick(31);
        pulse_irq;
        checks++;
        if (underrun !== 1'b1 || din !== 4'h0) begin
            errors++;
            $display("FAIL ur_starved: got ur=%b din=%h want 1 0", underrun, din);
        end
        tick(10);
        hold_en = 1'b0;
        tick(20);
        checks++;
        if (din !== 4'h3 || underrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ur_late_byte: got din=%h ur=%b busy=%b want 3 1 1", din, underrun, busy);
        end
        pulse_irq;
        checks++;
        if (din !== 4'h4) begin
            errors++;
            $display("FAIL ur_din3: got %h want 4", din);
        end
        tick(31);
        pulse_irq;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ur_done: got done=%b busy=%b want 1 0", done, busy);
        end
        tick(2);
    endtask

    task automatic test_stop;
        int d0;
        pulse_start(16'h0010, 16'h0013);
        tick(30);
        pulse_irq;
        checks++;
        if (din !== 4'h2) begin
            errors++;
            $display("FAIL stop_din: got %h want 2", din);
        end
        tick(5);
        d0 = done_cnt;
        pulse_stop;
        checks++;
        if ({rom_cs, adpcm_rst, busy, din} !== {1'b0, 1'b1, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL stop_outputs: got cs=%b arst=%b busy=%b din=%h want 0 1 0 0", rom_cs, adpcm_rst, busy, din);
        end
        tick(5);
        pulse_irq;
        tick(5);
        pulse_irq;
        checks++;
        if (din !== 4'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_irq_idle: got din=%h busy=%b want 0 0", din, busy);
        end
        tick(2);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL stop_no_done: got %0d pulses want 0", done_cnt - d0);
        end
        // start and stop together: stop wins
        pulse_start(16'h0010, 16'h0013);
        tick(10);
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if ({busy, rom_cs, adpcm_rst} !== {1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL stop_wins: got busy=%b cs=%b arst=%b want 0 0 1", busy, rom_cs, adpcm_rst);
        end
        tick(2);
    endtask

    task automatic test_restart;
        logic [3:0] e [4];
        int d0;
        e = '{4'h9, 4'hA, 4'hB, 4'hC};
        hold_addr = 16'h0011;
        hold_en   = 1'b1;
        pulse_start(16'h0010, 16'h0013);
        tick(7);
        pulse_irq;
        tick(31);
        pulse_irq;
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL restart_pre_ur: got %b want 1", underrun);
        end
        d0 = done_cnt;
        pulse_start(16'h0020, 16'h0021);
        checks++;
        if ({underrun, busy, din, adpcm_rst, rom_addr} !== {1'b0, 1'b1, 4'h0, 1'b1, 16'h0020}) begin
            errors++;
            $display("FAIL restart_flush: got ur=%b busy=%b din=%h arst=%b addr=%h want 0 1 0 1 0020",
                     underrun, busy, din, adpcm_rst, rom_addr);
        end
        tick(2);
        checks++;
        if (din !== 4'h9 || adpcm_rst !== 1'b0) begin
            errors++;
            $display("FAIL restart_first: got din=%h arst=%b want 9 0", din, adpcm_rst);
        end
        tick(5);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (din !== e[k]) begin
                errors++;
                $display("FAIL restart_din%0d: got %h want %h", k, din, e[k]);
            end
            pulse_irq;
            if (k < 3) tick(31);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: got %b want 1", done);
        end
        tick(3);
        checks++;
        if (done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL restart_done_count: got %0d want 1", done_cnt - d0);
        end
        hold_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        pulse_start(16'h0010, 16'h0011);
        tick(10);
        rst = 1'b1;
        #1;
        checks++;
        if ({rom_addr, rom_cs, din, adpcm_rst, busy, done, underrun} !== {16'h0000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got addr=%h cs=%b din=%h arst=%b busy=%b done=%b ur=%b want 0000 0 0 1 0 0 0",
                     rom_addr, rom_cs, din, adpcm_rst, busy, done, underrun);
        end
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
        rom[16'h0010] = 8'h12;
        rom[16'h0011] = 8'h34;
        rom[16'h0012] = 8'h56;
        rom[16'h0013] = 8'h78;
        rom[16'hFFFF] = 8'hAB;
        rom[16'h0000] = 8'hCD;
        rom[16'h0020] = 8'h9A;
        rom[16'h0021] = 8'hBC;
        rst        = 1'b1;
        irq        = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        start_addr = 16'h0000;
        end_addr   = 16'h0000;
        hold_en    = 1'b0;
        hold_addr  = 16'h0000;
        tick(2);
        test_reset;
        rst = 1'b0;
        tick(2);
        test_basic;
        test_wrap;
        test_underrun;
        test_stop;
        test_restart;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
